// File: rtl/cpu_fetch_unit.sv
// Instruction fetch unit: samples the current PC, reads the instruction word over the bus,
// presents it to decode with valid/ready, and writes next_pc back to the PC register.
module cpu_fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned INST_BYTES     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] curr_pc,
  input  logic        fetch_en,
  input  logic        flush,
  input  logic        fault_clr,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] next_pc,
  output logic        pc_wr,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_OUT,
    S_DRAIN,
    S_FAULT
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] STEP     = 32'(INST_BYTES);

  localparam logic [1:0] CODE_NONE      = 2'd0;
  localparam logic [1:0] CODE_MISALIGN  = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT   = 2'd2;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [31:0] addr_q;
  logic        bus_req_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic [31:0] next_pc_q;
  logic        inst_valid_q;
  logic        fault_q;
  logic [1:0]  fault_code_q;
  logic [31:0] fault_addr_q;
  logic        timeout;

  assign timeout = (cnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      bus_req_q    <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      next_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= CODE_NONE;
      fault_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_en && !flush) begin
            addr_q <= curr_pc;
            cnt_q  <= '0;
            if (curr_pc[1:0] != 2'b00) begin
              state_q      <= S_FAULT;
              fault_q      <= 1'b1;
              fault_code_q <= CODE_MISALIGN;
              fault_addr_q <= curr_pc;
            end else begin
              state_q   <= S_REQ;
              bus_req_q <= 1'b1;
            end
          end
        end

        S_REQ: begin
          cnt_q <= cnt_q + 16'd1;
          // A flush with the ack already present needs no drain: the data is simply dropped.
          if (flush) begin
            bus_req_q <= 1'b0;
            state_q   <= bus_ack ? S_IDLE : S_DRAIN;
          end else if (bus_ack) begin
            bus_req_q    <= 1'b0;
            inst_q       <= bus_rdata;
            inst_pc_q    <= addr_q;
            next_pc_q    <= addr_q + STEP;
            inst_valid_q <= 1'b1;
            state_q      <= S_OUT;
          end else if (timeout) begin
            bus_req_q    <= 1'b0;
            fault_q      <= 1'b1;
            fault_code_q <= CODE_TIMEOUT;
            fault_addr_q <= addr_q;
            state_q      <= S_FAULT;
          end
        end

        S_OUT: begin
          if (flush || inst_ready) begin
            inst_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end

        S_DRAIN: begin
          cnt_q <= cnt_q + 16'd1;
          if (bus_ack || timeout) begin
            state_q <= S_IDLE;
          end
        end

        S_FAULT: begin
          if (fault_clr || flush) begin
            fault_q      <= 1'b0;
            fault_code_q <= CODE_NONE;
            fault_addr_q <= '0;
            state_q      <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_addr   = addr_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign next_pc    = next_pc_q;
  assign pc_wr      = (state_q == S_OUT) && inst_ready && !flush;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;
  assign fault_addr = fault_addr_q;

endmodule
